// File: rtl/gemm_scheduler_if.sv
// Upstream beat channel into gemm_scheduler: valid/ready handshake plus mode, tag, last and lanes.
interface gemm_scheduler_if #(
  parameter int unsigned FORMAT_WIDTH = 9,
  parameter int unsigned TAG_WIDTH    = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_mode;
  logic                      in_last;
  logic [TAG_WIDTH-1:0]      in_tag;
  logic [4*FORMAT_WIDTH-1:0] in_real;
  logic [4*FORMAT_WIDTH-1:0] in_imag;

  modport master (
    output in_valid,
    output in_mode,
    output in_last,
    output in_tag,
    output in_real,
    output in_imag,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  in_last,
    input  in_tag,
    input  in_real,
    input  in_imag,
    output in_ready
  );
endinterface

// File: rtl/gemm_scheduler.sv
// Issue controller for the 4-point complex GEMM datapath: mode-switch hold-off and result tracking.
// Optional performance counters are enabled by defining GEMM_SCHED_PERF_EN.
module gemm_scheduler #(
  parameter int unsigned FORMAT_WIDTH = 9,
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned MODE_HOLD    = 2,
  parameter int unsigned TAG_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  gemm_scheduler_if.slave           up,
  output logic [4*FORMAT_WIDTH-1:0] gemm_real,
  output logic [4*FORMAT_WIDTH-1:0] gemm_imag,
  output logic                      gemm_control,
  input  logic [4*FORMAT_WIDTH-1:0] gemm_out_real,
  input  logic [4*FORMAT_WIDTH-1:0] gemm_out_imag,
  output logic                      out_valid,
  output logic [4*FORMAT_WIDTH-1:0] out_real,
  output logic [4*FORMAT_WIDTH-1:0] out_imag,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      job_done,
`ifdef GEMM_SCHED_PERF_EN
  output logic [31:0]               perf_issue,
  output logic [31:0]               perf_switch,
  output logic [31:0]               perf_stall,
`endif
  output logic                      busy
);

  localparam int unsigned HoldW = $clog2(MODE_HOLD + 2);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StSwitch
  } state_e;

  state_e               r_state;
  logic                 r_cur_mode;
  logic [HoldW-1:0]     r_hold_cnt;
  logic [LATENCY-1:0]   r_pipe_valid;
  logic [LATENCY-1:0]   r_pipe_last;
  logic [TAG_WIDTH-1:0] r_pipe_tag [LATENCY];

  logic w_mode_match;
  logic w_accept;
  logic w_pipe_busy;
  logic w_hold_done;
  logic w_switch_enter;

  assign w_mode_match = (up.in_mode == r_cur_mode);
  // rst gates ready so nothing is accepted while reset is held.
  assign w_accept     = rst & up.in_valid & w_mode_match & (r_state != StSwitch);
  assign w_pipe_busy  = |r_pipe_valid;
  // The counter expires on this edge, so the new mode lands after the hold window.
  assign w_hold_done  = (r_hold_cnt <= HoldW'(1));
  assign w_switch_enter = (r_state != StSwitch) & up.in_valid & ~w_mode_match;

  assign up.in_ready   = w_accept;
  assign gemm_real     = w_accept ? up.in_real : '0;
  assign gemm_imag     = w_accept ? up.in_imag : '0;
  assign gemm_control  = r_cur_mode;

  assign out_valid = r_pipe_valid[LATENCY-1];
  assign out_tag   = r_pipe_tag[LATENCY-1];
  assign job_done  = r_pipe_valid[LATENCY-1] & r_pipe_last[LATENCY-1];
  assign out_real  = gemm_out_real;
  assign out_imag  = gemm_out_imag;
  assign busy      = w_pipe_busy | (r_state == StSwitch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cur_mode   <= 1'b0;
      r_hold_cnt   <= '0;
      r_pipe_valid <= '0;
      r_pipe_last  <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_pipe_tag[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_hold_cnt <= HoldW'(MODE_HOLD);
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - HoldW'(1);
      end

      for (int i = int'(LATENCY) - 1; i > 0; i--) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_last[i]  <= r_pipe_last[i-1];
        r_pipe_tag[i]   <= r_pipe_tag[i-1];
      end
      r_pipe_valid[0] <= w_accept;
      r_pipe_last[0]  <= w_accept & up.in_last;
      r_pipe_tag[0]   <= w_accept ? up.in_tag : '0;

      case (r_state)
        StIdle, StRun: begin
          if (w_switch_enter) begin
            r_state <= StSwitch;
          end else if (w_accept) begin
            r_state <= StRun;
          end else if (!up.in_valid && !w_pipe_busy) begin
            r_state <= StIdle;
          end
        end
        StSwitch: begin
          if (!up.in_valid) begin
            r_state <= w_pipe_busy ? StRun : StIdle;
          end else if (w_hold_done) begin
            r_cur_mode <= up.in_mode;
            r_state    <= StRun;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef GEMM_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue  <= '0;
      perf_switch <= '0;
      perf_stall  <= '0;
    end else begin
      if (w_accept) begin
        perf_issue <= perf_issue + 32'd1;
      end
      if (w_switch_enter) begin
        perf_switch <= perf_switch + 32'd1;
      end
      if (up.in_valid && !w_accept) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gemm_scheduler.sv
// Randomised scoreboard bench for gemm_scheduler against a timing-rule reference model.
module tb_gemm_scheduler;
  localparam int unsigned Fw  = 9;
  localparam int unsigned Tw  = 4;
  localparam int unsigned Dw  = 4 * Fw;
  localparam int          Lat = 4;
  localparam int          Hold = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [Dw-1:0] gemm_real, gemm_imag, gemm_out_real, gemm_out_imag, out_real, out_imag;
  logic          gemm_control, out_valid, job_done, busy;
  logic [Tw-1:0] out_tag;
`ifdef GEMM_SCHED_PERF_EN
  logic [31:0]   perf_issue, perf_switch, perf_stall;
`endif

  gemm_scheduler_if #(.FORMAT_WIDTH(Fw), .TAG_WIDTH(Tw)) up_if ();

  gemm_scheduler #(
    .FORMAT_WIDTH(Fw), .LATENCY(Lat), .MODE_HOLD(Hold), .TAG_WIDTH(Tw)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .up            (up_if.slave),
    .gemm_real     (gemm_real),
    .gemm_imag     (gemm_imag),
    .gemm_control  (gemm_control),
    .gemm_out_real (gemm_out_real),
    .gemm_out_imag (gemm_out_imag),
    .out_valid     (out_valid),
    .out_real      (out_real),
    .out_imag      (out_imag),
    .out_tag       (out_tag),
    .job_done      (job_done),
`ifdef GEMM_SCHED_PERF_EN
    .perf_issue    (perf_issue),
    .perf_switch   (perf_switch),
    .perf_stall    (perf_stall),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [Tw-1:0] tag;
    logic          last;
    int            due;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: mode in force, pending switch, cycle of the most recent issue.
  bit   m_cur  = 1'b0;
  bit   m_sw   = 1'b0;
  int   m_last = -100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    gemm_out_real = Dw'({$urandom(), $urandom()});
    gemm_out_imag = Dw'({$urandom(), $urandom()});
  end

  // Model: predicts handshake, control and busy; pushes expected results on each issue.
  initial forever begin
    bit exp_rdy;
    bit exp_busy;
    @(negedge clk);
    if (!rst) begin
      chk("ready_in_reset", 64'(up_if.in_ready), 64'd0);
      chk("out_valid_in_reset", 64'(out_valid), 64'd0);
      chk("busy_in_reset", 64'(busy), 64'd0);
      chk("ctrl_in_reset", 64'(gemm_control), 64'd0);
      m_cur  = 1'b0;
      m_sw   = 1'b0;
      m_last = -100;
      q.delete();
    end else begin
      exp_rdy  = !m_sw && up_if.in_valid && (up_if.in_mode == m_cur);
      exp_busy = m_sw || (cyc > m_last && cyc - m_last <= Lat);
      chk("in_ready", 64'(up_if.in_ready), 64'(exp_rdy));
      chk("gemm_control", 64'(gemm_control), 64'(m_cur));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("gemm_real", 64'(gemm_real), exp_rdy ? 64'(up_if.in_real) : 64'd0);
      chk("gemm_imag", 64'(gemm_imag), exp_rdy ? 64'(up_if.in_imag) : 64'd0);
      if (m_sw) begin
        if (!up_if.in_valid) begin
          m_sw = 1'b0;
        end else if (cyc >= m_last + Hold) begin
          m_cur = up_if.in_mode;
          m_sw  = 1'b0;
        end
      end else if (exp_rdy) begin
        m_last = cyc;
        q.push_back('{tag: up_if.in_tag, last: up_if.in_last, due: cyc + Lat});
      end else if (up_if.in_valid) begin
        m_sw = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a result is presented.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      chk("out_real_pass", 64'(out_real), 64'(gemm_out_real));
      chk("out_imag_pass", 64'(out_imag), 64'(gemm_out_imag));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("out_cycle", 64'(cyc), 64'(e.due));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("job_done", 64'(job_done), 64'(e.last));
        end
      end else begin
        chk("job_done_idle", 64'(job_done), 64'd0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          chk("missing_out_valid", 64'(out_valid), 64'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    up_if.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input bit mode, input bit last, input logic [Tw-1:0] tag);
    int n = 0;
    up_if.in_valid = 1'b1;
    up_if.in_mode  = mode;
    up_if.in_last  = last;
    up_if.in_tag   = tag;
    up_if.in_real  = Dw'({$urandom(), $urandom()});
    up_if.in_imag  = Dw'({$urandom(), $urandom()});
    forever begin
      @(negedge clk);
      if (up_if.in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 64'(up_if.in_ready), 64'd1);
        break;
      end
    end
    step();
    up_if.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    bit mode;
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit mode = 1'b0;
    up_if.in_valid = 1'b1;
    up_if.in_mode  = 1'b0;
    up_if.in_last  = 1'b0;
    up_if.in_tag   = '0;
    up_if.in_real  = '0;
    up_if.in_imag  = '0;
    step();
    do_reset();

    // Back-to-back job of five beats in mode 0.
    for (int i = 1; i <= 5; i++) send(1'b0, i == 5, Tw'(i));
    idle(8);

    // Mode switch right after an issue.
    do_reset();
    send(1'b0, 1'b1, 4'd1);
    send(1'b1, 1'b1, 4'd2);
    idle(8);
`ifdef GEMM_SCHED_PERF_EN
    chk("perf_issue", 64'(perf_issue), 64'd2);
    chk("perf_switch", 64'(perf_switch), 64'd1);
    chk("perf_stall", 64'(perf_stall), 64'd2);
`endif

    // Switch from idle with the hold window already expired.
    do_reset();
    idle(3);
    send(1'b1, 1'b1, 4'd7);
    idle(6);

    // Alternating valid.
    for (int i = 0; i < 6; i++) begin
      send(1'b1, i == 5, Tw'(i + 3));
      idle(1);
    end
    idle(6);

    // Reset in the middle of a burst, then a fresh beat.
    send(1'b1, 1'b0, 4'd10);
    send(1'b1, 1'b0, 4'd11);
    up_if.in_valid = 1'b1;
    do_reset();
    up_if.in_valid = 1'b0;
    idle(6);
    send(1'b0, 1'b1, 4'd12);
    idle(6);

    // Random traffic with mode changes, gaps and job boundaries.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) mode = ~mode;
      send(mode, $urandom_range(0, 3) == 0, Tw'($urandom()));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
